// File: rtl/norm_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// norm_arbiter_ctrl
//   Shares one combinational mantissa normalizer between NUM_REQ requesters.
//   Round-robin arbitration with a per-requester valid/ready handshake. The
//   exponent is adjusted by the leading-zero count. The output stage is
//   registered and holds its value under downstream backpressure.
//
//   Build option: define NORM_FLUSH_EN to flush underflowing results to zero.
//   If it is left undefined, underflowing results keep the shifted mantissa
//   and a wrapped exponent, with out_underflow set.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready per-requester handshake (ready is combinational)
//   req_mant/exp    packed per-requester operands, requester i at [i*W +: W]
//   out_valid/ready result handshake
//   out_mant/exp    normalized mantissa / adjusted exponent
//   out_id          granted requester index
//   out_zero        input mantissa was zero
//   out_underflow   leading-zero count exceeded the input exponent
// ---------------------------------------------------------------------------

// Combinational normalizer: counts leading zeros and left-justifies the
// mantissa. A zero input gives lz = MANT_W and mant_o = 0.
module normalization_module #(
  parameter  int MANT_W = 8,
  localparam int LZ_W   = $clog2(MANT_W) + 1
) (
  input  logic [MANT_W-1:0] mant_i,
  output logic [MANT_W-1:0] mant_o,
  output logic [LZ_W-1:0]   lz_o,
  output logic              exp_incr_o,
  output logic              not_full_norm_o
);
  always_comb begin
    lz_o = LZ_W'(MANT_W);
    // Ascending scan: the highest set bit is written last and wins.
    for (int i = 0; i < MANT_W; i++)
      if (mant_i[i]) lz_o = LZ_W'(MANT_W - 1 - i);
  end

  assign mant_o          = mant_i << lz_o;
  // The input carries no overflow bit, so a right shift is never needed.
  assign exp_incr_o      = 1'b0;
  assign not_full_norm_o = (lz_o != '0);
endmodule

module norm_arbiter_ctrl #(
  parameter  int MANT_W  = 8,
  parameter  int EXP_W   = 8,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int LZ_W    = $clog2(MANT_W) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*MANT_W-1:0] req_mant,
  input  logic [NUM_REQ*EXP_W-1:0]  req_exp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MANT_W-1:0]         out_mant,
  output logic [EXP_W-1:0]          out_exp,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_zero,
  output logic                      out_underflow
);
  // Per-requester views of the packed operand buses.
  logic [NUM_REQ-1:0][MANT_W-1:0] mant_arr;
  logic [NUM_REQ-1:0][EXP_W-1:0]  exp_arr;
  assign mant_arr = req_mant;
  assign exp_arr  = req_exp;

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              out_valid_q;
  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [ID_W-1:0]   out_id_q;
  logic              out_zero_q, out_zero_d;
  logic              out_uflow_q, out_uflow_d;

  // The output register can accept a new result when it is empty or draining.
  logic load_en;
  assign load_en = !out_valid_q || out_ready;

  // Round-robin search that starts at the pointer and wraps.
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      automatic int idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  logic xfer;
  assign xfer = load_en && gnt_found;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  // The pointer moves past the winner. It changes only when a transfer happens.
  assign ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  // Shared normalizer datapath for the granted requester.
  logic [MANT_W-1:0] sel_mant, norm_mant;
  logic [EXP_W-1:0]  sel_exp;
  logic [LZ_W-1:0]   lz;
  logic              norm_unused_incr, norm_unused_nfn;
  assign sel_mant = mant_arr[gnt_idx];
  assign sel_exp  = exp_arr[gnt_idx];

  normalization_module #(.MANT_W(MANT_W)) u_norm (
    .mant_i          (sel_mant),
    .mant_o          (norm_mant),
    .lz_o            (lz),
    .exp_incr_o      (norm_unused_incr),
    .not_full_norm_o (norm_unused_nfn)
  );

  logic [EXP_W-1:0] lz_ext, exp_sub;
  logic             is_zero, is_uflow;
  assign lz_ext   = EXP_W'(lz);
  assign exp_sub  = sel_exp - lz_ext;           // wraps modulo 2^EXP_W
  assign is_zero  = (lz == LZ_W'(MANT_W));
  assign is_uflow = !is_zero && (lz_ext > sel_exp);

  always_comb begin
    out_mant_d  = norm_mant;
    out_exp_d   = exp_sub;
    out_zero_d  = 1'b0;
    out_uflow_d = 1'b0;
    if (is_zero) begin
      out_mant_d = '0;
      out_exp_d  = '0;
      out_zero_d = 1'b1;
    end else if (is_uflow) begin
      out_uflow_d = 1'b1;
`ifdef NORM_FLUSH_EN
      out_mant_d = '0;
      out_exp_d  = '0;
`else
      out_mant_d = norm_mant;
      out_exp_d  = exp_sub;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_id_q    <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else if (load_en) begin
      // If the register drains with no new grant, it goes empty and keeps its stale data.
      out_valid_q <= xfer;
      if (xfer) begin
        ptr_q       <= ptr_d;
        out_mant_q  <= out_mant_d;
        out_exp_q   <= out_exp_d;
        out_id_q    <= gnt_idx;
        out_zero_q  <= out_zero_d;
        out_uflow_q <= out_uflow_d;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_mant      = out_mant_q;
  assign out_exp       = out_exp_q;
  assign out_id        = out_id_q;
  assign out_zero      = out_zero_q;
  assign out_underflow = out_uflow_q;
endmodule
